// File: rtl/mcu_mux_array_k.sv
// Registered routing crossbar between M = N+K-1 line-buffer banks and N convolution units.
// Owns the bank-rotation base pointer; every output is registered one cycle behind the inputs.
module mcu_mux_array_k #(
    parameter int N           = 2,
    parameter int K           = 3,
    parameter int BITS_IMAGEN = 8,
    parameter int BITS_DATA   = 13,
    localparam int M          = N + K - 1,
    localparam int W          = (M > 1) ? $clog2(M) : 1
) (
    input  logic                           i_CLK,
    input  logic                           i_rst_n,
    input  logic [1:0]                     i_state,
    input  logic                           i_valid,
    input  logic [W-1:0]                   i_memSelect,
    input  logic [BITS_IMAGEN-1:0]         i_Data,
    input  logic [M*BITS_DATA-1:0]         i_MemData,
    input  logic [N*BITS_DATA-1:0]         i_DataConv,
    input  logic                           i_rotate,
    input  logic                           i_clear,
    output logic [N*K*BITS_IMAGEN-1:0]     o_DataConv,
    output logic [M*BITS_DATA-1:0]         o_MemData,
    output logic [M-1:0]                   o_MemWe,
    output logic [BITS_DATA-1:0]           o_Data,
    output logic                           o_valid,
    output logic [W-1:0]                   o_base,
    output logic                           o_err
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_PROC = 2'b01,
        ST_OUT  = 2'b10,
        ST_IDLE = 2'b11
    } state_t;

    localparam logic [W:0]   M_EXT  = (W + 1)'(M);
    localparam logic [W-1:0] N_STEP = W'(N % M);

    // Offsets never exceed M-1, so the raw sum stays below 2M-1 and one subtract wraps it.
    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] c);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, c};
        if (s >= M_EXT) s = s - M_EXT;
        return s[W-1:0];
    endfunction

    state_t                       state;
    logic                         sel_ok;
    logic                         valid_d;
    logic                         err_d;
    logic [N*K*BITS_IMAGEN-1:0]   conv_d;
    logic [M*BITS_DATA-1:0]       mem_d;
    logic [M-1:0]                 we_d;
    logic [BITS_DATA-1:0]         data_d;
    logic [W-1:0]                 base_d;

    assign state  = state_t'(i_state);
    assign sel_ok = ({1'b0, i_memSelect} < M_EXT);

    always_comb begin
        conv_d  = '0;
        mem_d   = '0;
        we_d    = '0;
        data_d  = '0;
        err_d   = 1'b0;
        valid_d = i_valid && (state != ST_IDLE);
        if (valid_d) begin
            unique case (state)
                ST_LOAD: begin
                    if (sel_ok) begin
                        we_d[i_memSelect] = 1'b1;
                        mem_d[int'(i_memSelect)*BITS_DATA +: BITS_DATA] = BITS_DATA'(i_Data);
                    end else begin
                        err_d = 1'b1;
                    end
                end
                ST_PROC: begin
                    for (int i = 0; i < N; i++) begin
                        for (int j = 0; j < K; j++) begin
                            conv_d[(i*K+j)*BITS_IMAGEN +: BITS_IMAGEN] =
                                i_MemData[int'(mod_add(o_base, W'(i+j)))*BITS_DATA +: BITS_IMAGEN];
                        end
                        // Unit i writes back into the bank holding its first tap.
                        mem_d[int'(mod_add(o_base, W'(i)))*BITS_DATA +: BITS_DATA] =
                            i_DataConv[i*BITS_DATA +: BITS_DATA];
                        we_d[mod_add(o_base, W'(i))] = 1'b1;
                    end
                end
                ST_OUT: begin
                    if (sel_ok) begin
                        data_d = i_MemData[int'(i_memSelect)*BITS_DATA +: BITS_DATA];
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Rotation ignores i_valid only through clear; a rotate must itself be a valid PROC beat.
    always_comb begin
        base_d = o_base;
        if (i_clear) begin
            base_d = '0;
        end else if (i_rotate && i_valid && (state == ST_PROC)) begin
            base_d = mod_add(o_base, N_STEP);
        end
    end

    always_ff @(posedge i_CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_DataConv <= '0;
            o_MemData  <= '0;
            o_MemWe    <= '0;
            o_Data     <= '0;
            o_valid    <= 1'b0;
            o_err      <= 1'b0;
            o_base     <= '0;
        end else begin
            o_DataConv <= conv_d;
            o_MemData  <= mem_d;
            o_MemWe    <= we_d;
            o_Data     <= data_d;
            o_valid    <= valid_d;
            o_err      <= err_d;
            o_base     <= base_d;
        end
    end

endmodule

// File: tb/tb_mcu_mux_array_k.sv
// Bench for mcu_mux_array_k with N=3, K=3 (M=5 banks, so out-of-range selects exist).
// Reference model works from bank contents and modulo arithmetic on an integer base pointer.
module tb_mcu_mux_array_k;
    localparam int N  = 3;
    localparam int K  = 3;
    localparam int BI = 8;
    localparam int BD = 13;
    localparam int M  = N + K - 1;
    localparam int W  = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [1:0]           i_state;
    logic                 i_valid;
    logic [W-1:0]         i_memSelect;
    logic [BI-1:0]        i_Data;
    logic [M*BD-1:0]      i_MemData;
    logic [N*BD-1:0]      i_DataConv;
    logic                 i_rotate;
    logic                 i_clear;
    logic [N*K*BI-1:0]    o_DataConv;
    logic [M*BD-1:0]      o_MemData;
    logic [M-1:0]         o_MemWe;
    logic [BD-1:0]        o_Data;
    logic                 o_valid;
    logic [W-1:0]         o_base;
    logic                 o_err;

    mcu_mux_array_k #(.N(N), .K(K), .BITS_IMAGEN(BI), .BITS_DATA(BD)) dut (
        .i_CLK       (clk),
        .i_rst_n     (rst_n),
        .i_state     (i_state),
        .i_valid     (i_valid),
        .i_memSelect (i_memSelect),
        .i_Data      (i_Data),
        .i_MemData   (i_MemData),
        .i_DataConv  (i_DataConv),
        .i_rotate    (i_rotate),
        .i_clear     (i_clear),
        .o_DataConv  (o_DataConv),
        .o_MemData   (o_MemData),
        .o_MemWe     (o_MemWe),
        .o_Data      (o_Data),
        .o_valid     (o_valid),
        .o_base      (o_base),
        .o_err       (o_err)
    );

    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_bad = 0;
    int            m_b   = 0;
    logic [BD-1:0] banks   [M];
    logic [BD-1:0] conv_in [N];

    task automatic chk(input string tag, input string nm, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s.%s observed %0h expected %0h", tag, nm, got, exp);
        end
    endtask

    task automatic drive(input int st, input logic v, input int sel, input logic [BI-1:0] d,
                         input logic rot, input logic clr);
        i_state     = 2'(st);
        i_valid     = v;
        i_memSelect = W'(sel);
        i_Data      = d;
        i_rotate    = rot;
        i_clear     = clr;
        for (int m = 0; m < M; m++) i_MemData[m*BD +: BD] = banks[m];
        for (int i = 0; i < N; i++) i_DataConv[i*BD +: BD] = conv_in[i];
    endtask

    // Model one clock: expected outputs come from the current inputs and the pre-edge base.
    task automatic step(input string tag);
        logic [N*K*BI-1:0] e_conv;
        logic [M*BD-1:0]   e_mem;
        logic [M-1:0]      e_we;
        logic [BD-1:0]     e_data;
        logic              e_err;
        logic              e_valid;
        int                st, sel, nb, bk;
        st      = int'(i_state);
        sel     = int'(i_memSelect);
        e_conv  = '0;
        e_mem   = '0;
        e_we    = '0;
        e_data  = '0;
        e_err   = 1'b0;
        e_valid = i_valid && (st != 3);
        if (e_valid) begin
            if (st == 0) begin
                if (sel < M) begin
                    e_we[sel] = 1'b1;
                    e_mem[sel*BD +: BD] = {{(BD-BI){1'b0}}, i_Data};
                end else e_err = 1'b1;
            end else if (st == 1) begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < K; j++) begin
                        bk = (m_b + i + j) % M;
                        e_conv[(i*K+j)*BI +: BI] = banks[bk][BI-1:0];
                    end
                    bk = (m_b + i) % M;
                    e_mem[bk*BD +: BD] = conv_in[i];
                    e_we[bk] = 1'b1;
                end
            end else begin
                if (sel < M) e_data = banks[sel];
                else e_err = 1'b1;
            end
        end
        if (i_clear) nb = 0;
        else if (i_rotate && i_valid && st == 1) nb = (m_b + N) % M;
        else nb = m_b;
        @(posedge clk);
        #1;
        chk(tag, "conv",  128'(o_DataConv), 128'(e_conv));
        chk(tag, "mem",   128'(o_MemData),  128'(e_mem));
        chk(tag, "we",    128'(o_MemWe),    128'(e_we));
        chk(tag, "data",  128'(o_Data),     128'(e_data));
        chk(tag, "valid", 128'(o_valid),    128'(e_valid));
        chk(tag, "err",   128'(o_err),      128'(e_err));
        chk(tag, "base",  128'(o_base),     128'(nb));
        m_b = nb;
    endtask

    task automatic check_zero(input string tag);
        chk(tag, "conv",  128'(o_DataConv), 128'(0));
        chk(tag, "mem",   128'(o_MemData),  128'(0));
        chk(tag, "we",    128'(o_MemWe),    128'(0));
        chk(tag, "data",  128'(o_Data),     128'(0));
        chk(tag, "valid", 128'(o_valid),    128'(0));
        chk(tag, "err",   128'(o_err),      128'(0));
        chk(tag, "base",  128'(o_base),     128'(0));
    endtask

    int rot_seq [5] = '{3, 1, 4, 2, 0};

    initial begin
        rst_n = 1'b0;
        for (int m = 0; m < M; m++) banks[m] = '0;
        for (int i = 0; i < N; i++) conv_in[i] = '0;
        drive(3, 1'b0, 0, 8'h00, 1'b0, 1'b0);
        #1;
        check_zero("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // LOAD: in-range, top bank, out-of-range, rotate ignored
        drive(0, 1'b1, 2, 8'hA5, 1'b0, 1'b0);
        step("load2");
        chk("load2", "we_const", 128'(o_MemWe), 128'(5'b00100));
        chk("load2", "bank2", 128'(o_MemData[2*BD +: BD]), 128'(13'h0A5));
        drive(0, 1'b1, 4, 8'h3C, 1'b0, 1'b0);
        step("load4");
        drive(0, 1'b1, 5, 8'h77, 1'b0, 1'b0);
        step("load_oor");
        chk("load_oor", "err_const", 128'(o_err), 128'(1));
        drive(0, 1'b1, 1, 8'h11, 1'b1, 1'b0);
        step("load_rot");
        chk("load_rot", "base_const", 128'(o_base), 128'(0));

        // PROC at b=0 with low bytes 1..5 and random upper bits
        for (int m = 0; m < M; m++) banks[m] = {5'($urandom), 8'(m + 1)};
        conv_in[0] = 13'h111;
        conv_in[1] = 13'h222;
        conv_in[2] = 13'h333;
        drive(1, 1'b1, 0, 8'h00, 1'b0, 1'b0);
        step("proc_b0");
        chk("proc_b0", "we_const", 128'(o_MemWe), 128'(5'b00111));
        chk("proc_b0", "u1tap2", 128'(o_DataConv[5*BI +: BI]), 128'(8'd4));

        // Rotation wrap 0,3,1,4,2,0
        for (int k = 0; k < 5; k++) begin
            drive(1, 1'b1, 0, 8'h00, 1'b1, 1'b0);
            step("rot");
            chk("rot", "seq", 128'(o_base), 128'(rot_seq[k]));
            if (k == 3) chk("rot_b4", "we_const", 128'(o_MemWe), 128'(5'b10011));
        end

        // OUT in range and out of range
        banks[3] = 13'h1ABC;
        drive(2, 1'b1, 3, 8'h00, 1'b0, 1'b0);
        step("out3");
        chk("out3", "data_const", 128'(o_Data), 128'(13'h1ABC));
        drive(2, 1'b1, 6, 8'h00, 1'b0, 1'b0);
        step("out_oor");

        // Walk b to 2, then clear and rotate together
        for (int k = 0; k < 4; k++) begin
            drive(1, 1'b1, 0, 8'h00, 1'b1, 1'b0);
            step("walk");
        end
        drive(1, 1'b1, 0, 8'h00, 1'b1, 1'b1);
        step("clr_rot");
        chk("clr_rot", "base_const", 128'(o_base), 128'(0));

        // Rotate gated by valid and by state; idle and invalid beats produce zeros
        drive(1, 1'b1, 0, 8'h00, 1'b1, 1'b0);
        step("to_b3");
        drive(1, 1'b0, 0, 8'h00, 1'b1, 1'b0);
        step("rot_novalid");
        chk("rot_novalid", "base_const", 128'(o_base), 128'(3));
        drive(3, 1'b1, 2, 8'h55, 1'b1, 1'b0);
        step("idle_rot");
        drive(2, 1'b0, 1, 8'h00, 1'b0, 1'b0);
        step("out_novalid");

        // Async reset in the middle of PROC at b=2
        for (int k = 0; k < 3; k++) begin
            drive(1, 1'b1, 0, 8'h00, 1'b1, 1'b0);
            step("walk2");
        end
        drive(1, 1'b1, 0, 8'h00, 1'b0, 1'b0);
        step("pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        m_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 1'b1, 0, 8'h00, 1'b0, 1'b0);
        step("post_rst");

        // Randomized traffic
        for (int t = 0; t < 300; t++) begin
            for (int m = 0; m < M; m++) banks[m] = BD'($urandom);
            for (int i = 0; i < N; i++) conv_in[i] = BD'($urandom);
            drive($urandom_range(0, 3), ($urandom_range(0, 3) != 0), $urandom_range(0, 7),
                  8'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
